// File: rtl/rv32_m_pkg.sv
// rv32_m_pkg
// Shared types for the M-extension dispatch slice: FSM state encoding,
// funct3 codes for MUL..REMU, and the operation tuple used as the result
// cache key.
// XLEN follows the core-wide define and falls back to 32 when the core
// header has not been pulled in ahead of this package.

`ifndef XLEN
`define XLEN 32
`endif

package rv32_m_pkg;

  localparam int XLEN_DEF = `XLEN;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } m_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Operation identity: two operands plus funct3 uniquely determine a result
  typedef struct packed {
    logic [XLEN_DEF-1:0] rs1;
    logic [XLEN_DEF-1:0] rs2;
    logic [2:0]          f3;
  } m_op_t;

endpackage

// File: rtl/rv32_m_result_cache.sv
// rv32_m_result_cache
// Single-entry memo of the last completed M operation and its result.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (invalidates entry)
//   i_lookup_op      operation being requested this cycle
//   i_upd            store i_upd_op / i_upd_data as the new entry
//   o_hit            entry valid and matches i_lookup_op (forced 0 if CACHE_EN=0)
//   o_data           cached result

module rv32_m_result_cache
  import rv32_m_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int CACHE_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  m_op_t           i_lookup_op,
  input  logic            i_upd,
  input  m_op_t           i_upd_op,
  input  logic [XLEN-1:0] i_upd_data,
  output logic            o_hit,
  output logic [XLEN-1:0] o_data
);

  logic            valid_q;
  m_op_t           op_q;
  logic [XLEN-1:0] data_q;

  // The entry is overwritten on every completed operation; reset only needs
  // to drop the valid bit, but clearing the key and data keeps the entry
  // deterministic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
    end else if (i_upd) begin
      valid_q <= 1'b1;
      op_q    <= i_upd_op;
      data_q  <= i_upd_data;
    end
  end

  assign o_hit  = (CACHE_EN != 0) && valid_q && (i_lookup_op == op_q);
  assign o_data = data_q;

endmodule

// File: rtl/rv32_m_dispatch.sv
// rv32_m_dispatch
// Issue/writeback stage between the execute stage and the external M unit.
// Captures a request, issues a single enable pulse, stalls the core until the
// result returns, and writes it back with rd. A last-result cache lets a
// repeated operation skip the M unit, a flush drains any in-flight result, and
// a watchdog abandons an operation the M unit never acknowledges.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req, i_rs1, i_rs2, i_f3, i_rd  core request (held while o_stall=1)
//   i_flush                       kill the in-flight request
//   o_stall                       core must hold its request
//   o_wb_en, o_wb_rd, o_wb_data   writeback strobe, register and data
//   o_err                         one-cycle pulse when the watchdog fires
//   o_m_en, o_m_rs1, o_m_rs2, o_m_f3  issue interface to the M unit
//   i_m_res, i_m_ack              M unit result and completion pulse

module rv32_m_dispatch
  import rv32_m_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CACHE_EN       = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_err,
  output logic            o_m_en,
  output logic [XLEN-1:0] o_m_rs1,
  output logic [XLEN-1:0] o_m_rs2,
  output logic [2:0]      o_m_f3,
  input  logic [XLEN-1:0] i_m_res,
  input  logic            i_m_ack
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  m_state_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       wb_rd_q;
  logic [XLEN-1:0]  wb_data_q;

  m_op_t            lookup_op;
  m_op_t            cur_op;
  logic             cache_hit;
  logic             cache_upd;
  logic [XLEN-1:0]  cache_data;
  logic             timeout;

  assign lookup_op = '{rs1: i_rs1, rs2: i_rs2, f3: i_f3};
  assign cur_op    = '{rs1: o_m_rs1, rs2: o_m_rs2, f3: o_m_f3};

  // Watchdog fires on the last allowed waiting cycle; an ack in that same
  // cycle takes priority so a just-in-time result is never thrown away.
  assign timeout = ((state_q == WAIT) || (state_q == DRAIN)) &&
                   (cnt_q == CNT_LAST) && !i_m_ack;

  // Only a result that will actually be written back is worth remembering.
  assign cache_upd = (state_q == WAIT) && i_m_ack && !i_flush;

  rv32_m_result_cache #(
    .XLEN     (XLEN),
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_lookup_op (lookup_op),
    .i_upd       (cache_upd),
    .i_upd_op    (cur_op),
    .i_upd_data  (i_m_res),
    .o_hit       (cache_hit),
    .o_data      (cache_data)
  );

  // Strobes are decoded from state; gating with i_rst keeps a reset that lands
  // mid-operation from leaking a final pulse in the reset cycle itself.
  assign o_stall   = i_req && (state_q != DONE);
  assign o_m_en    = (state_q == ISSUE) && !i_flush && !i_rst;
  assign o_wb_en   = (state_q == DONE) && !i_flush && !i_rst;
  assign o_err     = timeout && !i_rst;
  assign o_wb_rd   = wb_rd_q;
  assign o_wb_data = wb_data_q;

  // Main sequencer. The o_m_* operand registers load only on a cache miss in
  // IDLE so the M unit sees stable operands from issue through its ack, even
  // if the core is flushed and starts presenting a different request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      o_m_rs1   <= '0;
      o_m_rs2   <= '0;
      o_m_f3    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req && !i_flush) begin
            wb_rd_q <= i_rd;
            if (cache_hit) begin
              wb_data_q <= cache_data;
              state_q   <= DONE;
            end else begin
              o_m_rs1 <= i_rs1;
              o_m_rs2 <= i_rs2;
              o_m_f3  <= i_f3;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= i_flush ? IDLE : WAIT;
        end
        WAIT: begin
          if (i_m_ack) begin
            if (i_flush) begin
              state_q <= IDLE;
            end else begin
              wb_data_q <= i_m_res;
              state_q   <= DONE;
            end
          end else if (timeout) begin
            state_q <= IDLE;
          end else begin
            // The watchdog keeps counting across a flush into DRAIN so the
            // total time spent waiting on one issue stays bounded.
            cnt_q <= cnt_q + CNT_W'(1);
            if (i_flush) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_m_ack || timeout) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
